// File: rtl/jedro_1_defines.sv
// Shared constants for the jedro_1 instruction memory path.
package jedro_1_defines;

  localparam logic [6:0]  OPCODE_OPIMM = 7'b0010011;
  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR    = {12'h000, 5'd0, 3'b000, 5'd0, OPCODE_OPIMM};

  // Selects what the fetch port presents: the array output or a NOP.
  typedef enum logic {
    OUT_NOP = 1'b0,
    OUT_RAM = 1'b1
  } out_sel_e;

endpackage

// File: rtl/jedro_1_sram_1r1w.sv
// Plain word array with one synchronous read port and one synchronous write
// port. The read is read-first: a same-edge write to the read word is not seen.
// The read register only updates on an enabled read, so the output holds
// its value between reads.
module jedro_1_sram_1r1w
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);

  // Contents start as NOPs so an unloaded fetch executes harmlessly.
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS] = '{default: DATA_WIDTH'(NOP_INSTR)};

  // Write port: whole word only.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read port: registered, samples the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/jedro_1_instr_ram.sv
// Instruction RAM for the jedro_1 core: one-cycle fetch port plus a
// program-load write port. Reset clears the response path only, never the
// array contents.
// Optional macro JEDRO_1_INSTR_RAM_ERR_EN adds alignment/range checking and
// the sticky err_o flag; without it addresses wrap modulo the array size.
module jedro_1_instr_ram
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ram_re_i,
  input  logic [ADDR_WIDTH-1:0] ram_addr_i,
  output logic [DATA_WIDTH-1:0] ram_rdata_o,
  output logic                  ram_rvalid_o,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_wdata_i
`ifdef JEDRO_1_INSTR_RAM_ERR_EN
  ,output logic                 err_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [IDX_W-1:0]      ridx;
  logic [IDX_W-1:0]      widx;
  logic                  rd_bad;
  logic                  ld_bad;
  logic                  sram_re;
  logic                  sram_we;
  logic [DATA_WIDTH-1:0] sram_rdata;
  out_sel_e              out_sel;

  assign ridx = ram_addr_i[IDX_W+1:2];
  assign widx = load_addr_i[IDX_W+1:2];

  // Byte-lane bits never index the array; high bits only matter when checked.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr_i[1:0], ram_addr_i[ADDR_WIDTH-1:IDX_W+2],
                              load_addr_i[1:0], load_addr_i[ADDR_WIDTH-1:IDX_W+2]};

`ifdef JEDRO_1_INSTR_RAM_ERR_EN
  assign rd_bad = (ram_addr_i[1:0] != 2'b00) || ((ram_addr_i >> (IDX_W + 2)) != '0);
  assign ld_bad = (load_addr_i >> (IDX_W + 2)) != '0;
`else
  assign rd_bad = 1'b0;
  assign ld_bad = 1'b0;
`endif

  // Requests seen while in reset are ignored; faulty accesses never touch the array.
  assign sram_re = ram_re_i & rstn_i & ~rd_bad;
  assign sram_we = load_we_i & rstn_i & ~ld_bad;

  jedro_1_sram_1r1w #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk_i   (clk_i),
    .re_i    (sram_re),
    .raddr_i (ridx),
    .rdata_o (sram_rdata),
    .we_i    (sram_we),
    .waddr_i (widx),
    .wdata_i (load_wdata_i)
  );

  // Response tracking: valid follows the request by one edge; the source
  // select only changes on a read so the data output holds between reads.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ram_rvalid_o <= 1'b0;
      out_sel      <= OUT_NOP;
    end else begin
      ram_rvalid_o <= ram_re_i;
      if (ram_re_i) out_sel <= rd_bad ? OUT_NOP : OUT_RAM;
    end
  end

  assign ram_rdata_o = (out_sel == OUT_RAM) ? sram_rdata : DATA_WIDTH'(NOP_INSTR);

`ifdef JEDRO_1_INSTR_RAM_ERR_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                   err_o <= 1'b0;
    else if ((ram_re_i & rd_bad) | (load_we_i & ld_bad)) err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_jedro_1_instr_ram.sv
// Self-checking bench for jedro_1_instr_ram against a word-array model.
module tb_jedro_1_instr_ram;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          ram_re_i;
  logic [AW-1:0] ram_addr_i;
  logic [DW-1:0] ram_rdata_o;
  logic          ram_rvalid_o;
  logic          load_we_i;
  logic [AW-1:0] load_addr_i;
  logic [DW-1:0] load_wdata_i;
`ifdef JEDRO_1_INSTR_RAM_ERR_EN
  logic          err_o;
  logic          exp_err;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rdata;
  logic        exp_rvalid;

  always #5 clk_i = ~clk_i;

  jedro_1_instr_ram #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .ram_re_i     (ram_re_i),
    .ram_addr_i   (ram_addr_i),
    .ram_rdata_o  (ram_rdata_o),
    .ram_rvalid_o (ram_rvalid_o),
    .load_we_i    (load_we_i),
    .load_addr_i  (load_addr_i),
    .load_wdata_i (load_wdata_i)
`ifdef JEDRO_1_INSTR_RAM_ERR_EN
    ,.err_o       (err_o)
`endif
  );

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef JEDRO_1_INSTR_RAM_ERR_EN
    return (a % 4 != 0) || (a >= DEPTH * 4);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit load_bad(input logic [31:0] a);
`ifdef JEDRO_1_INSTR_RAM_ERR_EN
    return a >= DEPTH * 4;
`else
    return 1'b0;
`endif
  endfunction

  // Apply one cycle of stimulus, advance the model at the edge, sample 1ns after.
  task automatic step(input logic re, input logic [31:0] ra,
                      input logic we, input logic [31:0] wa, input logic [31:0] wd);
    ram_re_i = re; ram_addr_i = ra;
    load_we_i = we; load_addr_i = wa; load_wdata_i = wd;
    @(posedge clk_i);
    if (!rstn_i) begin
      exp_rdata = NOP; exp_rvalid = 1'b0;
`ifdef JEDRO_1_INSTR_RAM_ERR_EN
      exp_err = 1'b0;
`endif
    end else begin
      exp_rvalid = re;
      if (re) exp_rdata = addr_bad(ra) ? NOP : model_mem[widx(ra)];
      if (we && !load_bad(wa)) model_mem[widx(wa)] = wd;
`ifdef JEDRO_1_INSTR_RAM_ERR_EN
      if ((re && addr_bad(ra)) || (we && load_bad(wa))) exp_err = 1'b1;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom, 1'b1, $urandom_range(0, 63) * 4, $urandom);
      vectors++;
      if (ram_rdata_o !== NOP) begin
        errors++; $display("FAIL reset_rdata cyc %0d: got %h want %h", i, ram_rdata_o, NOP);
      end
      vectors++;
      if (ram_rvalid_o !== 1'b0) begin
        errors++; $display("FAIL reset_rvalid cyc %0d: got %b want 0", i, ram_rvalid_o);
      end
`ifdef JEDRO_1_INSTR_RAM_ERR_EN
      vectors++;
      if (err_o !== 1'b0) begin
        errors++; $display("FAIL reset_err cyc %0d: got %b want 0", i, err_o);
      end
`endif
    end
    rstn_i = 1'b1;
  endtask

  task automatic test_load_readback();
    logic [31:0] prog [4];
    prog[0] = 32'h00108093; prog[1] = 32'h00208093;
    prog[2] = 32'h00308093; prog[3] = 32'h00408093;
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, i * 4, prog[i]);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i * 4, 1'b0, 0, 0);
      vectors++;
      if (ram_rdata_o !== prog[i] || ram_rvalid_o !== 1'b1 || exp_rdata !== prog[i]) begin
        errors++;
        $display("FAIL b2b_read word %0d: got %h/%b want %h/1", i, ram_rdata_o, ram_rvalid_o, prog[i]);
      end
    end
  endtask

  task automatic test_read_first();
    step(1'b1, 32'h8, 1'b1, 32'h8, 32'hDEADBEEF);
    vectors++;
    if (ram_rdata_o !== 32'h00308093) begin
      errors++; $display("FAIL read_first old: got %h want 00308093", ram_rdata_o);
    end
    step(1'b1, 32'h8, 1'b0, 0, 0);
    vectors++;
    if (ram_rdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_first new: got %h want deadbeef", ram_rdata_o);
    end
    // Read and load to different words in the same cycle.
    step(1'b1, 32'h4, 1'b1, 32'h10, 32'h12345678);
    step(1'b1, 32'h10, 1'b0, 0, 0);
    vectors++;
    if (ram_rdata_o !== 32'h12345678) begin
      errors++; $display("FAIL diff_word_load: got %h want 12345678", ram_rdata_o);
    end
  endtask

  task automatic test_hold();
    step(1'b1, 32'h4, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, $urandom, 1'b0, 0, 0);
      vectors++;
      if (ram_rdata_o !== 32'h00208093 || ram_rvalid_o !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc %0d: got %h/%b want 00208093/0", i, ram_rdata_o, ram_rvalid_o);
      end
    end
  endtask

  task automatic test_unloaded();
    step(1'b1, 32'h320, 1'b0, 0, 0);
    vectors++;
    if (ram_rdata_o !== NOP || ram_rvalid_o !== 1'b1) begin
      errors++; $display("FAIL unloaded_word: got %h/%b want %h/1", ram_rdata_o, ram_rvalid_o, NOP);
    end
  endtask

  task automatic test_reset_mid_read();
    step(1'b1, 32'h4, 1'b0, 0, 0);
    ram_re_i = 1'b1; ram_addr_i = 32'h8;
    #2 rstn_i = 1'b0;
    exp_rdata = NOP; exp_rvalid = 1'b0;
    #1;
    vectors++;
    if (ram_rdata_o !== NOP || ram_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h/%b want %h/0", ram_rdata_o, ram_rvalid_o, NOP);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'h0, 1'b1, 32'h0, 32'hBAD0BAD0);
      vectors++;
      if (ram_rvalid_o !== 1'b0) begin
        errors++; $display("FAIL reset_no_valid cyc %0d: got %b want 0", i, ram_rvalid_o);
      end
    end
    rstn_i = 1'b1;
    step(1'b0, 0, 1'b0, 0, 0);
    vectors++;
    if (ram_rvalid_o !== 1'b0 || ram_rdata_o !== NOP) begin
      errors++; $display("FAIL post_reset_idle: got %h/%b want %h/0", ram_rdata_o, ram_rvalid_o, NOP);
    end
    step(1'b1, 32'h0, 1'b0, 0, 0);
    vectors++;
    if (ram_rdata_o !== 32'h00108093 || ram_rvalid_o !== 1'b1) begin
      errors++; $display("FAIL retained: got %h/%b want 00108093/1", ram_rdata_o, ram_rvalid_o);
    end
  endtask

  task automatic test_range();
`ifdef JEDRO_1_INSTR_RAM_ERR_EN
    step(1'b1, 32'h402, 1'b0, 0, 0);
    vectors++;
    if (ram_rdata_o !== NOP || ram_rvalid_o !== 1'b1 || err_o !== 1'b1) begin
      errors++; $display("FAIL misaligned: got %h/%b err %b want %h/1 err 1", ram_rdata_o, ram_rvalid_o, err_o, NOP);
    end
    step(1'b1, 32'h400, 1'b0, 0, 0);
    vectors++;
    if (ram_rdata_o !== NOP || err_o !== 1'b1) begin
      errors++; $display("FAIL out_of_range: got %h err %b want %h err 1", ram_rdata_o, err_o, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0, 1'b0, 0, 0);
      vectors++;
      if (err_o !== 1'b1 || ram_rdata_o !== exp_rdata) begin
        errors++; $display("FAIL err_sticky cyc %0d: got %h err %b want %h err 1", i, ram_rdata_o, err_o, exp_rdata);
      end
    end
    rstn_i = 1'b0;
    step(1'b0, 0, 1'b0, 0, 0);
    rstn_i = 1'b1;
    vectors++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b want 0", err_o);
    end
`else
    step(1'b1, 32'h400, 1'b0, 0, 0);
    vectors++;
    if (ram_rdata_o !== model_mem[0] || ram_rdata_o !== 32'h00108093) begin
      errors++; $display("FAIL wrap_read: got %h want 00108093", ram_rdata_o);
    end
    step(1'b0, 0, 1'b1, 32'h404, 32'hCAFEF00D);
    step(1'b1, 32'h4, 1'b0, 0, 0);
    vectors++;
    if (ram_rdata_o !== 32'hCAFEF00D) begin
      errors++; $display("FAIL wrap_load: got %h want cafef00d", ram_rdata_o);
    end
`endif
  endtask

  task automatic test_random();
    logic        re, we;
    logic [31:0] ra, wa;
    for (int i = 0; i < 400; i++) begin
      re = 1'($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, DEPTH - 1) * 4;
      wa = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, DEPTH - 1) * 4;
      if (($urandom_range(0, 4) == 0)) wa = ra;
      step(re, ra, we, wa, $urandom);
      vectors++;
      if (ram_rvalid_o !== exp_rvalid || ram_rdata_o !== exp_rdata) begin
        errors++;
        $display("FAIL random cyc %0d addr %h: got %h/%b want %h/%b", i, ra, ram_rdata_o, ram_rvalid_o, exp_rdata, exp_rvalid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    exp_rdata = NOP; exp_rvalid = 1'b0;
`ifdef JEDRO_1_INSTR_RAM_ERR_EN
    exp_err = 1'b0;
`endif
    rstn_i = 1'b0; ram_re_i = 1'b0; ram_addr_i = '0;
    load_we_i = 1'b0; load_addr_i = '0; load_wdata_i = '0;
    #1;
    test_reset();
    test_unloaded();
    test_load_readback();
    test_read_first();
    test_hold();
    test_reset_mid_read();
    test_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
